act_pipe: RTL and testbench

- Parametrised successor to the single-lane ReLU unit: LANES-wide signed activation engine with run-time selectable mode (ReLU, leaky ReLU, clamp, passthrough).
- Two-stage elastic pipeline with valid/ready handshakes and a per-run clip counter.
- Sits in the Versat datapath between a memory/stream unit producing tensor words and the consumer unit.

---
 rtl/act_pipe.sv | 138 +++++++++++++
 tb/tb_act_pipe.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/act_pipe.sv
// rtl/act_pipe.sv - LANES-wide signed activation engine, two-stage elastic pipeline
module act_pipe #(
  parameter int DATA_W  = 32,
  parameter int LANES   = 4,
  parameter int COUNT_W = 32,
  parameter int SHIFT_W = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      running,
  input  logic [1:0]                mode,
  input  logic [SHIFT_W-1:0]        shift,
  input  logic [DATA_W-1:0]         clip_max,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*DATA_W-1:0]   in0,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*DATA_W-1:0]   out0,
  output logic [COUNT_W-1:0]        clip_count,
  output logic                      busy
);

  localparam int PC_W  = $clog2(LANES + 1);
  localparam int SUM_W = COUNT_W + PC_W;

  logic                     running_q;
  logic [1:0]               cfg_mode;
  logic [SHIFT_W-1:0]       cfg_shift;
  logic [DATA_W-1:0]        cfg_clip;
  logic                     s1_valid;
  logic [LANES*DATA_W-1:0]  s1_data;
  logic                     s1_adv;
  logic                     s2_adv;
  logic                     run_rise;
  logic                     accept;
  logic [LANES*DATA_W-1:0]  lane_y;
  logic [LANES-1:0]         lane_clip;
  logic [PC_W-1:0]          clip_pop;
  logic [SUM_W-1:0]         clip_sum;
  logic [COUNT_W-1:0]       clip_next;

  // One lane of the activation; a negative clamp ceiling forces every lane to zero
  function automatic logic [DATA_W-1:0] lane_fn(
    input logic [DATA_W-1:0]  x,
    input logic [1:0]         md,
    input logic [SHIFT_W-1:0] sh,
    input logic [DATA_W-1:0]  cmax
  );
    logic [DATA_W-1:0] y;
    case (md)
      2'd0: y = x[DATA_W-1] ? '0 : x;
      2'd1: y = x[DATA_W-1] ? DATA_W'($signed(x) >>> sh) : x;
      2'd2: begin
        if (x[DATA_W-1] || cmax[DATA_W-1]) y = '0;
        else if ($signed(x) > $signed(cmax)) y = cmax;
        else y = x;
      end
      default: y = x;
    endcase
    return y;
  endfunction

  assign run_rise  = running && !running_q;
  assign s2_adv    = !out_valid || out_ready;
  assign s1_adv    = s1_valid && s2_adv;
  assign in_ready  = running && running_q && (!s1_valid || s1_adv);
  assign accept    = in_valid && in_ready;
  assign busy      = s1_valid || out_valid;

  // Per-lane result and clip flag for the word being offered
  always_comb begin
    lane_y    = '0;
    lane_clip = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_y[k*DATA_W +: DATA_W] = lane_fn(in0[k*DATA_W +: DATA_W], cfg_mode, cfg_shift, cfg_clip);
      lane_clip[k] = lane_y[k*DATA_W +: DATA_W] != in0[k*DATA_W +: DATA_W];
    end
  end

  // Number of lanes the current word modifies
  always_comb begin
    clip_pop = '0;
    for (int k = 0; k < LANES; k++) begin
      clip_pop = clip_pop + PC_W'(lane_clip[k]);
    end
  end

  // Any carry into the extension bits means the counter would wrap, so pin it at all-ones
  assign clip_sum  = {{PC_W{1'b0}}, clip_count} + {{COUNT_W{1'b0}}, clip_pop};
  assign clip_next = (clip_sum[SUM_W-1 -: PC_W] != '0) ? '1 : clip_sum[COUNT_W-1:0];

  // Run-edge tracking, per-run config latch and the saturating clip tally
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      running_q  <= 1'b0;
      cfg_mode   <= '0;
      cfg_shift  <= '0;
      cfg_clip   <= '0;
      clip_count <= '0;
    end else begin
      running_q <= running;
      if (run_rise) begin
        cfg_mode   <= mode;
        cfg_shift  <= shift;
        cfg_clip   <= clip_max;
        clip_count <= '0;
      end else if (accept) begin
        clip_count <= clip_next;
      end
    end
  end

  // Stage 1 captures the computed word and holds it while stage 2 is blocked
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_data  <= lane_y;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2 presents the word; it only changes when empty or being consumed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out0      <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) out0 <= s1_data;
    end
  end

endmodule

// File: tb/tb_act_pipe.sv
// tb/tb_act_pipe.sv - self-checking bench for act_pipe
module tb_act_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        running;
  logic [1:0]  mode;
  logic [4:0]  shift;
  logic [31:0] clip_max;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in0;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out0;
  logic [31:0] clip_count;
  logic        busy;

  logic        running2;
  logic        in_valid2;
  logic        in_ready2;
  logic [31:0] in0_2;
  logic        out_valid2;
  logic [31:0] out0_2;
  logic [2:0]  clip_count2;
  logic        busy2;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  act_pipe #(.DATA_W(32), .LANES(2), .COUNT_W(32), .SHIFT_W(5)) u_dut (
    .clk(clk), .rst(rst), .running(running), .mode(mode), .shift(shift),
    .clip_max(clip_max), .in_valid(in_valid), .in_ready(in_ready), .in0(in0),
    .out_valid(out_valid), .out_ready(out_ready), .out0(out0),
    .clip_count(clip_count), .busy(busy)
  );

  act_pipe #(.DATA_W(8), .LANES(4), .COUNT_W(3), .SHIFT_W(3)) u_sat (
    .clk(clk), .rst(rst), .running(running2), .mode(2'd0), .shift(3'd0),
    .clip_max(8'd0), .in_valid(in_valid2), .in_ready(in_ready2), .in0(in0_2),
    .out_valid(out_valid2), .out_ready(1'b1), .out0(out0_2),
    .clip_count(clip_count2), .busy(busy2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] mk(input logic [31:0] l0, input logic [31:0] l1);
    return {l1, l0};
  endfunction

  // Specification-level lane rule: floor division for leaky, min/max for clamp
  function automatic longint m_lane(input longint x, input int md, input int sh, input longint cm);
    longint p, q;
    case (md)
      0: return (x < 0) ? 0 : x;
      1: begin
        if (x >= 0) return x;
        if (sh >= 32) return -1;
        p = longint'(1) << sh;
        q = x / p;
        if (q * p != x) q = q - 1;
        return q;
      end
      2: begin
        if (cm < 0 || x < 0) return 0;
        return (x > cm) ? cm : x;
      end
      default: return x;
    endcase
  endfunction

  typedef struct { logic [63:0] word; int acc; } ent_t;
  ent_t        mq[$];
  logic [63:0] out_log[$];
  int          out_cyc[$];
  int          acc_cyc[$];
  logic        m_run_q = 1'b0;
  int          m_mode = 0;
  int          m_shift = 0;
  longint      m_cmax = 0;
  longint      m_count = 0;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_out = '0;
  logic        blocked_seen = 1'b0;

  // Cycle-by-cycle comparison against an occupancy/queue model of the pipeline
  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out0", out0, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_clip_count", clip_count, 0);
      chk("rst_busy", busy, 0);
      mq.delete();
      m_run_q = 1'b0; m_mode = 0; m_shift = 0; m_cmax = 0; m_count = 0;
      prev_stall = 1'b0;
    end else begin
      chk("busy", busy, mq.size() > 0);
      chk("clip_count", clip_count, m_count);
      chk("out_valid", out_valid, (mq.size() > 0) && (cyc >= mq[0].acc + 1));
      chk("in_ready", in_ready, running && m_run_q && (mq.size() < 2 || out_ready));
      if (prev_stall) chk("stall_hold", out0, prev_out);
      if (running && in_valid && !in_ready && mq.size() == 2) blocked_seen = 1'b1;
      if (out_valid && out_ready) begin
        if (mq.size() == 0) chk("out_spurious", 1, 0);
        else begin
          chk("out_word", out0, mq[0].word);
          out_log.push_back(out0);
          out_cyc.push_back(cyc);
          void'(mq.pop_front());
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_out = out0;
      if (in_valid && in_ready) begin
        logic [63:0] w;
        int nclip;
        ent_t e;
        w = '0;
        nclip = 0;
        for (int k = 0; k < 2; k++) begin
          longint x, y;
          x = longint'($signed(in0[k*32 +: 32]));
          y = m_lane(x, m_mode, m_shift, m_cmax);
          w[k*32 +: 32] = y[31:0];
          if (y != x) nclip++;
        end
        e.word = w;
        e.acc = cyc + 1;
        mq.push_back(e);
        acc_cyc.push_back(cyc);
        if (m_count + nclip > 64'hFFFFFFFF) m_count = 64'hFFFFFFFF;
        else m_count = m_count + nclip;
      end
      if (running && !m_run_q) begin
        m_mode = int'(mode);
        m_shift = int'(shift);
        m_cmax = longint'($signed(clip_max));
        m_count = 0;
      end
      m_run_q = running;
    end
  end

  logic [63:0] stim_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [1:0] md, input logic [4:0] sh, input logic [31:0] cm);
    running = 1'b0;
    tick();
    mode = md; shift = sh; clip_max = cm;
    running = 1'b1;
    tick();
  endtask

  task automatic drive_all();
    int guard;
    guard = 0;
    while (stim_q.size() > 0 && guard < 200) begin
      in0 = stim_q[0];
      in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) void'(stim_q.pop_front());
      tick();
      guard++;
    end
    in_valid = 1'b0;
    in0 = '0;
    chk("drive_timeout", stim_q.size(), 0);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (busy && g < 30) begin
      tick();
      g++;
    end
    chk("drain_timeout", busy, 0);
  endtask

  task automatic clear_logs();
    out_log.delete(); out_cyc.delete(); acc_cyc.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; running = 1'b0; mode = 2'd0; shift = '0; clip_max = '0;
    in_valid = 1'b1; in0 = 64'hDEADBEEF_CAFEF00D; out_ready = 1'b1;
    running2 = 1'b0; in_valid2 = 1'b0; in0_2 = '0;
    repeat (2) tick();
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out0", out0, 0);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_clip_count", clip_count, 0);
    chk("reset_busy", busy, 0);
    rst = 1'b1; in_valid = 1'b0; in0 = '0;
    tick();
    running = 1'b1;
    @(negedge clk);
    chk("ir_before_rise", in_ready, 0);
    @(negedge clk);
    chk("ir_after_rise", in_ready, 1);
    tick();

    // ReLU streaming
    start_run(2'd0, 5'd0, 32'd0);
    clear_logs();
    stim_q = '{mk(5, -3), mk(-1, 32'h7FFFFFFF), mk(32'h80000000, 7)};
    drive_all();
    drain();
    chk("relu_n", out_log.size(), 3);
    if (out_log.size() == 3) begin
      chk("relu_o0", out_log[0], mk(5, 0));
      chk("relu_o1", out_log[1], mk(0, 32'h7FFFFFFF));
      chk("relu_o2", out_log[2], mk(0, 7));
      chk("relu_latency", out_cyc[0] - acc_cyc[0], 2);
      chk("relu_gap01", out_cyc[1] - out_cyc[0], 1);
      chk("relu_gap12", out_cyc[2] - out_cyc[1], 1);
    end
    chk("relu_count", clip_count, 3);

    // Leaky ReLU, shift 2 then shift 31
    start_run(2'd1, 5'd2, 32'd0);
    clear_logs();
    stim_q = '{mk(-8, -1), mk(-5, 12)};
    drive_all();
    drain();
    chk("leaky_n", out_log.size(), 2);
    if (out_log.size() == 2) begin
      chk("leaky_o0", out_log[0], mk(-2, -1));
      chk("leaky_o1", out_log[1], mk(-2, 12));
    end
    chk("leaky_count", clip_count, 2);
    start_run(2'd1, 5'd31, 32'd0);
    chk("leaky31_cnt_clear", clip_count, 0);
    clear_logs();
    stim_q = '{mk(-7, 4)};
    drive_all();
    drain();
    if (out_log.size() == 1) chk("leaky31_o0", out_log[0], mk(-1, 4));
    else chk("leaky31_n", out_log.size(), 1);
    chk("leaky31_count", clip_count, 1);

    // Clamp, positive and negative ceiling
    start_run(2'd2, 5'd0, 32'd100);
    clear_logs();
    stim_q = '{mk(150, -4), mk(100, 99)};
    drive_all();
    drain();
    chk("clamp_n", out_log.size(), 2);
    if (out_log.size() == 2) begin
      chk("clamp_o0", out_log[0], mk(100, 0));
      chk("clamp_o1", out_log[1], mk(100, 99));
    end
    chk("clamp_count", clip_count, 2);
    start_run(2'd2, 5'd0, -5);
    clear_logs();
    stim_q = '{mk(3, -9)};
    drive_all();
    drain();
    if (out_log.size() == 1) chk("clampneg_o0", out_log[0], mk(0, 0));
    else chk("clampneg_n", out_log.size(), 1);
    chk("clampneg_count", clip_count, 2);

    // Backpressure with a mid-run mode change that must be ignored
    start_run(2'd0, 5'd0, 32'd0);
    mode = 2'd3;
    clear_logs();
    blocked_seen = 1'b0;
    for (int i = 0; i < 6; i++) stim_q.push_back(mk(i + 1, -(i + 1)));
    fork
      drive_all();
      begin
        for (int i = 0; i < 10; i++) begin
          out_ready = !(i >= 3 && i <= 6);
          tick();
        end
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_n", out_log.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < out_log.size()) chk("bp_word", out_log[i], mk(i + 1, 0));
    chk("bp_blocked_seen", blocked_seen, 1);
    chk("bp_count", clip_count, 6);

    // Drop running with two words in flight
    start_run(2'd1, 5'd1, 32'd0);
    clear_logs();
    stim_q = '{mk(-4, 3), mk(-6, 2)};
    drive_all();
    running = 1'b0;
    mode = 2'd0;
    chk("drop_busy", busy, 1);
    drain();
    chk("drop_n", out_log.size(), 2);
    if (out_log.size() == 2) begin
      chk("drop_o0", out_log[0], mk(-2, 3));
      chk("drop_o1", out_log[1], mk(-3, 2));
    end
    chk("drop_count_hold", clip_count, 2);

    // Asynchronous reset mid-stream
    start_run(2'd0, 5'd0, 32'd0);
    out_ready = 1'b0;
    stim_q = '{mk(-1, 2), mk(3, -4)};
    drive_all();
    #2;
    chk("prerst_valid", out_valid, 1);
    chk("prerst_count", clip_count, 2);
    rst = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_count", clip_count, 0);
    chk("arst_busy", busy, 0);
    running = 1'b0;
    out_ready = 1'b1;
    tick();
    rst = 1'b1;
    tick();

    // Saturating counter on the narrow instance
    running2 = 1'b1;
    tick();
    chk("sat_in_ready", in_ready2, 1);
    in_valid2 = 1'b1;
    in0_2 = 32'hFFFFFFFF;
    tick();
    chk("sat_count1", clip_count2, 4);
    tick();
    chk("sat_count2", clip_count2, 7);
    tick();
    chk("sat_count3", clip_count2, 7);
    in_valid2 = 1'b0;
    tick();
    chk("sat_out_valid", out_valid2, 1);
    chk("sat_out0", out0_2, 0);
    running2 = 1'b0;
    repeat (3) tick();
    chk("sat_busy", busy2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
